// File: rtl/intr_ctrl_if.sv
// Interrupt controller bundle: source lines, CSR-side controls, the commit/mret
// inputs from the pipeline, and the redirect/CSR write-back outputs.
interface intr_ctrl_if #(
  parameter int unsigned DW      = 32,
  parameter int unsigned NUM_SRC = 4
);
  logic [NUM_SRC-1:0] irq;
  logic [NUM_SRC-1:0] mode;
  logic [NUM_SRC-1:0] mie;
  logic               gie;
  logic [DW-1:0]      mtvec;
  logic               commit_valid;
  logic [DW-1:0]      pc_m;
  logic               is_mret;

  logic               redirect;
  logic [DW-1:0]      redirect_pc;
  logic               mepc_we;
  logic [DW-1:0]      mepc;
  logic               mcause_we;
  logic [DW-1:0]      mcause;
  logic [NUM_SRC-1:0] mip;
  logic               in_handler;

  modport master (
    output irq, mode, mie, gie, mtvec, commit_valid, pc_m, is_mret,
    input  redirect, redirect_pc, mepc_we, mepc, mcause_we, mcause, mip, in_handler
  );

  modport slave (
    input  irq, mode, mie, gie, mtvec, commit_valid, pc_m, is_mret,
    output redirect, redirect_pc, mepc_we, mepc, mcause_we, mcause, mip, in_handler
  );
endinterface

// File: rtl/intr_ctrl.sv
// Machine-mode interrupt controller: synchronised edge/level sources, fixed priority,
// registered one-cycle trap-entry and mret redirects with mepc/mcause write-back.
module intr_ctrl #(
  parameter int unsigned DW          = 32,
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CAUSE_BASE  = 16
) (
  input logic        clk,
  input logic        rst_n,
  intr_ctrl_if.slave ic
);
  localparam int unsigned IdW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CW  = DW - 1;

  typedef enum logic [1:0] {StIdle, StTrap, StHandler, StReturn} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] s, edge_q, pend_q, pend_d, pend, el;
  logic [IdW-1:0]     id_q, win_id;
  logic [CW-1:0]      cause_w;
  logic [DW-1:0]      base, vec_off, target;
  logic               take;
  logic               redirect_q, we_q;
  logic [DW-1:0]      redirect_pc_q, mepc_q, mcause_q;

  assign s = sync_q[SYNC_STAGES-1];

  // Edge-mode bits live in pend_q; level-mode bits follow the synchronised line.
  always_comb begin
    pend_d = pend_q;
    if (state_q == StTrap) pend_d[id_q] = 1'b0;
    pend_d = (pend_d | (s & ~edge_q)) & ic.mode;
  end

  assign pend = (pend_q & ic.mode) | (s & ~ic.mode);
  assign el   = pend & ic.mie;

  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (el[i]) win_id = IdW'(i);
    end
  end

  assign cause_w = CW'(CAUSE_BASE) + CW'(win_id);
  assign base    = {ic.mtvec[DW-1:2], 2'b00};
  assign vec_off = DW'({cause_w, 2'b00});
  assign target  = (ic.mtvec[1:0] == 2'b01) ? base + vec_off : base;

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ic.gie && (|el) && ic.commit_valid) begin
          state_d = StTrap;
          take    = 1'b1;
        end else if (ic.is_mret) begin
          state_d = StReturn;
        end
      end
      StTrap:    state_d = StHandler;
      StHandler: if (ic.is_mret) state_d = StReturn;
      StReturn:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      state_q       <= StIdle;
      edge_q        <= '0;
      pend_q        <= '0;
      id_q          <= '0;
      redirect_q    <= 1'b0;
      we_q          <= 1'b0;
      redirect_pc_q <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
    end else begin
      sync_q[0] <= ic.irq;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      state_q    <= state_d;
      edge_q     <= s;
      pend_q     <= pend_d;
      redirect_q <= (state_d == StTrap) || (state_d == StReturn);
      we_q       <= take;
      // Redirect target is captured on the entering edge so outputs come straight from flops.
      if (take) begin
        id_q          <= win_id;
        mepc_q        <= ic.pc_m;
        mcause_q      <= {1'b1, cause_w};
        redirect_pc_q <= target;
      end else if (state_d == StReturn) begin
        redirect_pc_q <= mepc_q;
      end
    end
  end

  assign ic.redirect    = redirect_q;
  assign ic.redirect_pc = redirect_pc_q;
  assign ic.mepc_we     = we_q;
  assign ic.mcause_we   = we_q;
  assign ic.mepc        = mepc_q;
  assign ic.mcause      = mcause_q;
  assign ic.mip         = pend;
  assign ic.in_handler  = (state_q == StHandler);
endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl with hand-computed expectations.
module tb_intr_ctrl;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  intr_ctrl_if #(.DW(32), .NUM_SRC(4)) bus ();

  intr_ctrl #(
    .DW(32), .NUM_SRC(4), .SYNC_STAGES(2), .CAUSE_BASE(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ic    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_handler();
    bus.is_mret = 1'b1;
    step();
    bus.is_mret = 1'b0;
    step();
  endtask

  task automatic test_reset();
    n_tests++; if (bus.redirect !== 1'b0) begin n_fail++;
      $display("FAIL reset_redirect got %0b want 0", bus.redirect); end
    n_tests++; if (bus.mepc_we !== 1'b0 || bus.mcause_we !== 1'b0) begin n_fail++;
      $display("FAIL reset_we got %0b%0b want 00", bus.mepc_we, bus.mcause_we); end
    n_tests++; if (bus.mepc !== 32'h0 || bus.mcause !== 32'h0) begin n_fail++;
      $display("FAIL reset_csr got %h/%h want 0/0", bus.mepc, bus.mcause); end
    n_tests++; if (bus.mip !== 4'h0 || bus.in_handler !== 1'b0) begin n_fail++;
      $display("FAIL reset_state got mip %h hnd %0b want 0/0", bus.mip, bus.in_handler); end
    n_tests++; if (bus.redirect_pc !== 32'h0) begin n_fail++;
      $display("FAIL reset_rpc got %h want 0", bus.redirect_pc); end
  endtask

  task automatic test_single_edge();
    bus.irq[2] = 1'b1;
    step();
    bus.irq[2] = 1'b0;
    step();
    n_tests++; if (bus.redirect !== 1'b0) begin n_fail++;
      $display("FAIL se_early got %0b want 0", bus.redirect); end
    step();
    n_tests++; if (bus.mip !== 4'b0100 || bus.redirect !== 1'b0) begin n_fail++;
      $display("FAIL se_pend got mip %b rd %0b want 0100/0", bus.mip, bus.redirect); end
    step();
    n_tests++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h0000_0148) begin n_fail++;
      $display("FAIL se_trap got %0b %h want 1 00000148", bus.redirect, bus.redirect_pc); end
    n_tests++; if (bus.mcause !== 32'h8000_0012 || bus.mepc !== 32'h0000_0040) begin n_fail++;
      $display("FAIL se_csr got %h/%h want 80000012/00000040", bus.mcause, bus.mepc); end
    n_tests++; if (bus.mepc_we !== 1'b1 || bus.mcause_we !== 1'b1) begin n_fail++;
      $display("FAIL se_we got %0b%0b want 11", bus.mepc_we, bus.mcause_we); end
    step();
    n_tests++; if (bus.mip[2] !== 1'b0 || bus.in_handler !== 1'b1) begin n_fail++;
      $display("FAIL se_hnd got mip %b hnd %0b want 0/1", bus.mip, bus.in_handler); end
    n_tests++; if (bus.redirect !== 1'b0 || bus.mepc_we !== 1'b0) begin n_fail++;
      $display("FAIL se_pulse got %0b/%0b want 0/0", bus.redirect, bus.mepc_we); end
    bus.is_mret = 1'b1;
    step();
    n_tests++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h40 || bus.in_handler !== 1'b0)
      begin n_fail++;
      $display("FAIL se_ret got %0b %h %0b want 1 00000040 0",
               bus.redirect, bus.redirect_pc, bus.in_handler); end
    bus.is_mret = 1'b0;
    step();
    n_tests++; if (bus.redirect !== 1'b0) begin n_fail++;
      $display("FAIL se_idle got %0b want 0", bus.redirect); end
  endtask

  task automatic test_priority();
    bus.mtvec = 32'h0000_0200;
    bus.pc_m  = 32'h0000_0084;
    bus.irq   = 4'b1010;
    for (int i = 0; i < 4; i++) step();
    n_tests++; if (bus.redirect !== 1'b1 || bus.mcause !== 32'h8000_0011 ||
                   bus.redirect_pc !== 32'h200) begin n_fail++;
      $display("FAIL pr_first got %0b %h %h want 1 80000011 00000200",
               bus.redirect, bus.mcause, bus.redirect_pc); end
    step();
    n_tests++; if (bus.mip !== 4'b1000) begin n_fail++;
      $display("FAIL pr_mip got %b want 1000", bus.mip); end
    bus.is_mret = 1'b1;
    step();
    n_tests++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h84) begin n_fail++;
      $display("FAIL pr_ret got %0b %h want 1 00000084", bus.redirect, bus.redirect_pc); end
    bus.is_mret = 1'b0;
    step();
    n_tests++; if (bus.redirect !== 1'b0) begin n_fail++;
      $display("FAIL pr_gap got %0b want 0", bus.redirect); end
    step();
    n_tests++; if (bus.redirect !== 1'b1 || bus.mcause !== 32'h8000_0013) begin n_fail++;
      $display("FAIL pr_second got %0b %h want 1 80000013", bus.redirect, bus.mcause); end
    bus.irq = 4'b0000;
    step();
    finish_handler();
    n_tests++; if (bus.mip !== 4'b0000) begin n_fail++;
      $display("FAIL pr_clear got %b want 0000", bus.mip); end
  endtask

  task automatic test_level();
    bus.mode   = 4'hE;
    bus.mie    = 4'hE;
    bus.irq[0] = 1'b1;
    step();
    step();
    n_tests++; if (bus.mip[0] !== 1'b1) begin n_fail++;
      $display("FAIL lv_pend got %0b want 1", bus.mip[0]); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (bus.redirect !== 1'b0) begin n_fail++;
        $display("FAIL lv_masked cyc %0d got %0b want 0", i, bus.redirect); end
    end
    bus.mie = 4'hF;
    step();
    n_tests++; if (bus.redirect !== 1'b1 || bus.mcause !== 32'h8000_0010) begin n_fail++;
      $display("FAIL lv_trap got %0b %h want 1 80000010", bus.redirect, bus.mcause); end
    step();
    bus.irq[0] = 1'b0;
    for (int i = 0; i < 3; i++) step();
    finish_handler();
    bus.mie    = 4'hE;
    bus.irq[0] = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.irq[0] = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_tests++; if (bus.mip[0] !== 1'b0) begin n_fail++;
      $display("FAIL lv_drop got %0b want 0", bus.mip[0]); end
    bus.mie = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (bus.redirect !== 1'b0) begin n_fail++;
        $display("FAIL lv_notake cyc %0d got %0b want 0", i, bus.redirect); end
    end
    bus.mode = 4'hF;
  endtask

  task automatic test_no_nesting();
    bus.mtvec  = 32'h0000_0101;
    bus.pc_m   = 32'h0000_0040;
    bus.irq[2] = 1'b1;
    step();
    bus.irq[2] = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_tests++; if (bus.redirect !== 1'b1) begin n_fail++;
      $display("FAIL nn_trap got %0b want 1", bus.redirect); end
    step();
    bus.irq[0] = 1'b1;
    step();
    bus.irq[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++; if (bus.redirect !== 1'b0) begin n_fail++;
        $display("FAIL nn_hold cyc %0d got %0b want 0", i, bus.redirect); end
    end
    n_tests++; if (bus.mip[0] !== 1'b1 || bus.in_handler !== 1'b1) begin n_fail++;
      $display("FAIL nn_pend got %0b/%0b want 1/1", bus.mip[0], bus.in_handler); end
    bus.is_mret = 1'b1;
    step();
    n_tests++; if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h40) begin n_fail++;
      $display("FAIL nn_ret got %0b %h want 1 00000040", bus.redirect, bus.redirect_pc); end
    bus.is_mret = 1'b0;
    step();
    n_tests++; if (bus.redirect !== 1'b0) begin n_fail++;
      $display("FAIL nn_gap got %0b want 0", bus.redirect); end
    step();
    n_tests++; if (bus.redirect !== 1'b1 || bus.mcause !== 32'h8000_0010 ||
                   bus.redirect_pc !== 32'h140) begin n_fail++;
      $display("FAIL nn_src0 got %0b %h %h want 1 80000010 00000140",
               bus.redirect, bus.mcause, bus.redirect_pc); end
    step();
    finish_handler();
  endtask

  task automatic test_commit_hold();
    bus.commit_valid = 1'b0;
    bus.irq[2]       = 1'b1;
    step();
    bus.irq[2] = 1'b0;
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      n_tests++; if (bus.redirect !== 1'b0 || bus.mip[2] !== 1'b1) begin n_fail++;
        $display("FAIL ch_hold cyc %0d got rd %0b mip2 %0b want 0/1", i, bus.redirect,
                 bus.mip[2]); end
    end
    bus.commit_valid = 1'b1;
    step();
    n_tests++; if (bus.redirect !== 1'b1 || bus.mcause !== 32'h8000_0012) begin n_fail++;
      $display("FAIL ch_trap got %0b %h want 1 80000012", bus.redirect, bus.mcause); end
    step();
    finish_handler();
  endtask

  task automatic test_reset_in_trap();
    bus.pc_m = 32'h0000_0090;
    bus.irq  = 4'b1100;
    step();
    bus.irq = 4'b0000;
    for (int i = 0; i < 3; i++) step();
    n_tests++; if (bus.redirect !== 1'b1 || bus.mip !== 4'b1100) begin n_fail++;
      $display("FAIL rt_trap got %0b %b want 1 1100", bus.redirect, bus.mip); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.redirect !== 1'b0 || bus.mepc_we !== 1'b0 || bus.mcause_we !== 1'b0)
      begin n_fail++;
      $display("FAIL rt_strobes got %0b%0b%0b want 000", bus.redirect, bus.mepc_we,
               bus.mcause_we); end
    n_tests++; if (bus.mepc !== 32'h0 || bus.mcause !== 32'h0 || bus.redirect_pc !== 32'h0)
      begin n_fail++;
      $display("FAIL rt_regs got %h %h %h want 0 0 0", bus.mepc, bus.mcause, bus.redirect_pc); end
    n_tests++; if (bus.mip !== 4'h0 || bus.in_handler !== 1'b0) begin n_fail++;
      $display("FAIL rt_state got %b %0b want 0000 0", bus.mip, bus.in_handler); end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++; if (bus.redirect !== 1'b0 || bus.mip !== 4'h0) begin n_fail++;
        $display("FAIL rt_lost cyc %0d got %0b %b want 0 0000", i, bus.redirect, bus.mip); end
    end
  endtask

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    rst_n            = 1'b0;
    bus.irq          = 4'h0;
    bus.mode         = 4'hF;
    bus.mie          = 4'hF;
    bus.gie          = 1'b1;
    bus.mtvec        = 32'h0000_0101;
    bus.commit_valid = 1'b1;
    bus.pc_m         = 32'h0000_0040;
    bus.is_mret      = 1'b0;
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_single_edge();
    test_priority();
    test_level();
    test_no_nesting();
    test_commit_hold();
    test_reset_in_trap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
Parametrised machine-mode interrupt controller for the pipelined RISC-V core. It replaces the fixed two-line timer/external scheme with NUM_SRC synchronised sources, each with per-source edge or level mode and fixed priority. It handles trap entry and mret return as a registered one-cycle redirect/flush handshake with the fetch stage. It owns mepc/mcause write-back to the CSR file. It sits beside the CSR register block and drives the PC-select mux and the F/D flush.

Parameters:
DW, 32, data/PC width
NUM_SRC, 4, number of interrupt sources (1..16)
SYNC_STAGES, 2, synchroniser flops per source (>=2)
CAUSE_BASE, 16, mcause exception code of source 0; source n uses CAUSE_BASE+n

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
irq_i  in  NUM_SRC  asynchronous interrupt lines
mode_i  in  NUM_SRC  per-source mode: 1 = rising edge, 0 = level
mie_i  in  NUM_SRC  per-source enable (from mie CSR)
gie_i  in  1  global enable (mstatus.MIE)
mtvec_i  in  DW  trap vector; [1:0]=01 vectored, else direct; base = {mtvec_i[DW-1:2],2'b00}
commit_valid_i  in  1  memory-stage instruction valid and not stalled; trap may be taken
pc_m_i  in  DW  PC of memory-stage instruction (saved to mepc)
is_mret_i  in  1  mret decoded in execute stage
redirect_o  out  1  one-cycle PC override and F/D flush
redirect_pc_o  out  DW  PC target when redirect_o=1
mepc_we_o  out  1  mepc write strobe
mepc_o  out  DW  saved return PC
mcause_we_o  out  1  mcause write strobe
mcause_o  out  DW  {1'b1, zero-padded CAUSE_BASE+id}
mip_o  out  NUM_SRC  pending bits (mip view)
in_handler_o  out  1  handler active

Behaviour:
- Reset (rst_ni=0, asynchronous): state IDLE; synchronisers, edge history, pending, mepc and mcause registers all 0; every output 0.
- Sync: each irq_i bit passes through SYNC_STAGES flops giving s[n]. Edge history flop e[n]<=s[n].
- Pending, edge mode: p[n] is set on s[n]&~e[n]. It is cleared only in the TRAP cycle that takes source n. If set and clear coincide for the same source, set wins.
- Pending, level mode: p[n]=s[n]. It is not latched and follows the line.
- mip_o=p. Eligible vector el = p & mie_i.
- Selection: the lowest-index set bit of el wins (fixed priority).
- State IDLE: if gie_i & |el & commit_valid_i, then go to TRAP, latching the winning id and pc_m_i. Otherwise, if is_mret_i, go to RETURN. The trap wins over mret in the same cycle. With commit_valid_i=0 the block stays in IDLE and pending bits are held.
- State TRAP (exactly 1 cycle, outputs registered):
  - redirect_o=1, mepc_we_o=1, mcause_we_o=1.
  - mepc_o = latched PC.
  - mcause_o[DW-1]=1, low bits = CAUSE_BASE+id.
  - redirect_pc_o = base + 4*(CAUSE_BASE+id) when vectored, else base.
  - The edge-pending bit of id is cleared. Next state is HANDLER.
- State HANDLER: in_handler_o=1; new requests are not taken and remain pending (no nesting). is_mret_i moves to RETURN.
- State RETURN (1 cycle): redirect_o=1, redirect_pc_o=mepc_o, in_handler_o=0. Next state is IDLE; a pending request can trap no earlier than the following cycle.
- mret in IDLE: also goes through RETURN to mepc_o.
- Strobes: redirect_o, mepc_we_o and mcause_we_o are single-cycle pulses. mepc_o and mcause_o hold their values until the next TRAP.
- Latency, edge source: with irq_i high before clock edge k, p is set at edge k+SYNC_STAGES and TRAP is entered at edge k+SYNC_STAGES+1.
- Latency, level source: one edge sooner than edge mode.
- A level source deasserted before selection is never taken. Glitches shorter than one clock have undefined capture.
- Reset asserted mid-TRAP or mid-HANDLER aborts immediately to the reset values; no redirect is emitted.

Test Plan:
- NUM_SRC=4, mtvec_i=0x0000_0101, gie=1, mie=4'hF, mode=4'hF, pc_m_i=0x0000_0040; pulse irq_i[2] for 1 cycle:
  - TRAP 3 edges later; redirect_o pulse with redirect_pc_o=0x0000_0148.
  - mcause_o=0x8000_0012, mepc_o=0x0000_0040; mip_o[2] clears.
- irq_i[1] and irq_i[3] rise in the same cycle, direct mtvec 0x0000_0200:
  - First trap is source 1 (mcause 0x8000_0011, pc 0x200); mip_o[3] stays set.
  - After mret, RETURN redirects to mepc; next cycle source 3 traps (0x8000_0013).
- Level source 0 with mie_i[0]=0: no trap while mip_o[0]=1.
  - Set mie_i[0]=1: trap within 1 cycle.
  - Drop irq_i[0] before mie is set: no trap occurs.
- In HANDLER, fire irq_i[0] (edge): no redirect until mret. RETURN pulses redirect_pc_o=mepc_o, then source 0 traps on the following cycle.
- commit_valid_i held 0 for 10 cycles with irq_i[2] pending: no trap, mip_o[2]=1 throughout. Raising commit_valid_i gives TRAP on the next edge.
- Assert rst_ni=0 during TRAP: all outputs 0 immediately and state IDLE. A previously latched edge pending is lost.
